core_data_mem: RTL and testbench

Per-core data scratchpad that sits directly downstream of `Core`'s memory port (`enable_M`, `addr_M`, `wr_data_M` → `rd_data_M`, `ready_M`). It latches one core load/store request, waits a programmable access latency, performs the array access and returns a one-cycle `ready_M` pulse. A secondary host port lets the dispatcher preload or read back data between tasks. The host port is stalled only in the single cycle where the core access owns the array.

---
 rtl/core_data_mem.sv | 122 ++++++++++++
 tb/tb_core_data_mem.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_data_mem.sv
// Per-core data scratchpad: one latched core load/store with programmable latency,
// plus a host preload/readback port that yields only on the core's access cycle.
module core_data_mem #(
   parameter int REG_SIZE  = 8,
   parameter int ADDR_SIZE = 8,
   parameter int LATENCY   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           enable_M,
   input  logic [ADDR_SIZE-1:0] addr_M,
   input  logic [REG_SIZE-1:0]  wr_data_M,
   output logic [REG_SIZE-1:0]  rd_data_M,
   output logic                 ready_M,
   input  logic                 host_we,
   input  logic                 host_re,
   input  logic [ADDR_SIZE-1:0] host_addr,
   input  logic [REG_SIZE-1:0]  host_wdata,
   output logic [REG_SIZE-1:0]  host_rdata,
   output logic                 host_stall
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [REG_SIZE-1:0]  mem [2**ADDR_SIZE];

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 opWr_q, opWr_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [REG_SIZE-1:0]  wdata_q, wdata_d;
   logic [REG_SIZE-1:0]  rdData_q, rdData_d;
   logic                 ready_q, ready_d;
   logic [REG_SIZE-1:0]  hostRdata_q;
   logic                 coreWe;

   assign host_stall = (state_q == WAIT) && (cnt_q == 4'd0);
   assign rd_data_M  = rdData_q;
   assign ready_M    = ready_q;
   assign host_rdata = hostRdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         opWr_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdData_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opWr_q   <= opWr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdData_q <= rdData_d;
         ready_q  <= ready_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opWr_d   = opWr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdData_d = rdData_q;
      ready_d  = 1'b0;
      coreWe   = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_M != 2'b00) begin
               state_d = WAIT;
               cnt_d   = CNT_INIT;
               opWr_d  = enable_M[1];
               addr_d  = addr_M;
               wdata_d = wr_data_M;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = RESP;
               ready_d = 1'b1;
               if (opWr_q) begin
                  coreWe = 1'b1;
               end else begin
                  rdData_d = mem[addr_q];
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The core write and any host write can never coincide: the host is stalled on that edge.
   always_ff @(posedge clk) begin
      if (coreWe) begin
         mem[addr_q] <= wdata_q;
      end else if (host_we && !host_stall) begin
         mem[host_addr] <= host_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hostRdata_q <= '0;
      end else if (host_re && !host_we && !host_stall) begin
         hostRdata_q <= mem[host_addr];
      end
   end

endmodule

// File: tb/tb_core_data_mem.sv
// Self-checking bench for core_data_mem: edge-numbered behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_core_data_mem;

   localparam int RS  = 8;
   localparam int AS  = 8;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    enable_M;
   logic [AS-1:0] addr_M;
   logic [RS-1:0] wr_data_M;
   logic [RS-1:0] rd_data_M;
   logic          ready_M;
   logic          host_we;
   logic          host_re;
   logic [AS-1:0] host_addr;
   logic [RS-1:0] host_wdata;
   logic [RS-1:0] host_rdata;
   logic          host_stall;

   int vectors     = 0;
   int miscompares = 0;

   core_data_mem #(.REG_SIZE(RS), .ADDR_SIZE(AS), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable_M   (enable_M),
      .addr_M     (addr_M),
      .wr_data_M  (wr_data_M),
      .rd_data_M  (rd_data_M),
      .ready_M    (ready_M),
      .host_we    (host_we),
      .host_re    (host_re),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .host_stall (host_stall)
   );

   always #5 clk = ~clk;

   // Model: edges are numbered from reset release; a request accepted at edge N
   // is performed at edge N+LAT and the next request may be taken at access+2.
   logic [RS-1:0] mdlMem [256];
   bit            mdlValid [256];
   int            edgeN, accessEdge, freeEdge;
   bit            pending, pendWr, stallNow;
   logic [AS-1:0] pendAddr;
   logic [RS-1:0] pendData;
   logic          expReady;
   logic [RS-1:0] expRd, expHostRd;
   bit            expRdKnown, expHostKnown;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending      = 1'b0;
         expReady     = 1'b0;
         expRd        = '0;
         expHostRd    = '0;
         expRdKnown   = 1'b1;
         expHostKnown = 1'b1;
         edgeN        = 0;
         accessEdge   = 0;
         freeEdge     = 0;
      end else begin
         edgeN++;
         stallNow = pending && (edgeN == accessEdge);
         if (host_re && !host_we && !stallNow) begin
            expHostRd    = mdlMem[host_addr];
            expHostKnown = mdlValid[host_addr];
         end
         expReady = 1'b0;
         if (stallNow) begin
            expReady = 1'b1;
            pending  = 1'b0;
            freeEdge = edgeN + 2;
            if (pendWr) begin
               mdlMem[pendAddr]   = pendData;
               mdlValid[pendAddr] = 1'b1;
            end else begin
               expRd      = mdlMem[pendAddr];
               expRdKnown = mdlValid[pendAddr];
            end
         end else if (!pending && edgeN >= freeEdge && enable_M != 2'b00) begin
            pending    = 1'b1;
            accessEdge = edgeN + LAT;
            pendWr     = enable_M[1];
            pendAddr   = addr_M;
            pendData   = wr_data_M;
         end
         if (host_we && !stallNow) begin
            mdlMem[host_addr]   = host_wdata;
            mdlValid[host_addr] = 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         checkOutput("mdl_ready_M", {31'd0, ready_M}, {31'd0, expReady});
         checkOutput("mdl_host_stall", {31'd0, host_stall},
                     {31'd0, pending && (edgeN + 1 == accessEdge)});
         if (expRdKnown)   checkOutput("mdl_rd_data_M", {24'd0, rd_data_M}, {24'd0, expRd});
         if (expHostKnown) checkOutput("mdl_host_rdata", {24'd0, host_rdata}, {24'd0, expHostRd});
      end
   end

   task automatic applyStimulus(input logic [1:0] en, input logic [7:0] addr, input logic [7:0] wd,
                                input logic hwe, input logic hre, input logic [7:0] haddr,
                                input logic [7:0] hwd);
      enable_M   = en;
      addr_M     = addr;
      wr_data_M  = wd;
      host_we    = hwe;
      host_re    = hre;
      host_addr  = haddr;
      host_wdata = hwd;
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic idle();
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int pulses[$];
      int diff;
      reset = 1'b0;
      applyStimulus(2'b01, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) begin
         @(negedge clk);
         checkOutput("in_reset_ready", {31'd0, ready_M}, 32'd0);
      end
      step();
      idle();
      reset = 1'b1;
      checkOutput("rst_ready", {31'd0, ready_M}, 32'd0);
      checkOutput("rst_rd_data", {24'd0, rd_data_M}, 32'd0);
      checkOutput("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
      checkOutput("rst_stall", {31'd0, host_stall}, 32'd0);
      step(2);
      checkOutput("no_spurious_ready", {31'd0, ready_M}, 32'd0);

      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h03, 8'h08); step();
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h30, 8'h22); step();
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h11); step();
      idle(); step();

      applyStimulus(2'b01, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
      idle();
      checkOutput("rd_e0_ready", {31'd0, ready_M}, 32'd0);
      step();
      checkOutput("rd_e1_stall", {31'd0, host_stall}, 32'd1);
      step();
      checkOutput("rd_e2_ready", {31'd0, ready_M}, 32'd1);
      checkOutput("rd_e2_data", {24'd0, rd_data_M}, 32'h08);
      step();
      checkOutput("rd_e3_ready", {31'd0, ready_M}, 32'd0);
      checkOutput("rd_e3_data", {24'd0, rd_data_M}, 32'h08);

      applyStimulus(2'b11, 8'h10, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00); step();
      idle(); step(2);
      checkOutput("wr_ready", {31'd0, ready_M}, 32'd1);
      checkOutput("wr_rd_hold", {24'd0, rd_data_M}, 32'h08);
      step();
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h10, 8'h00); step();
      idle();
      checkOutput("host_rd_after_wr", {24'd0, host_rdata}, 32'h55);

      applyStimulus(2'b01, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
      idle(); step();
      checkOutput("hrd_stall_on", {31'd0, host_stall}, 32'd1);
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h03, 8'h00); step();
      checkOutput("hrd_dropped", {24'd0, host_rdata}, 32'h55);
      checkOutput("hrd_stall_off", {31'd0, host_stall}, 32'd0);
      step();
      checkOutput("hrd_after_stall", {24'd0, host_rdata}, 32'h08);
      idle();

      applyStimulus(2'b01, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
      idle(); step();
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h30, 8'h99); step();
      idle(); step();
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h30, 8'h00); step();
      idle();
      checkOutput("hwr_dropped", {24'd0, host_rdata}, 32'h22);

      applyStimulus(2'b01, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 12; i++) begin
         step();
         if (i == 4) idle();
         if (ready_M === 1'b1) pulses.push_back(i);
      end
      checkOutput("b2b_pulse_count", pulses.size(), 32'd2);
      diff = (pulses.size() >= 2) ? pulses[1] - pulses[0] : -1;
      checkOutput("b2b_spacing", diff, LAT + 2);

      applyStimulus(2'b11, 8'h20, 8'h33, 1'b0, 1'b0, 8'h00, 8'h00); step();
      idle(); step();
      reset = 1'b0;
      #1;
      checkOutput("midrst_ready", {31'd0, ready_M}, 32'd0);
      checkOutput("midrst_stall", {31'd0, host_stall}, 32'd0);
      step();
      reset = 1'b1;
      checkOutput("midrst_post_ready", {31'd0, ready_M}, 32'd0);
      step();
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h20, 8'h00); step();
      idle();
      checkOutput("midrst_mem_kept", {24'd0, host_rdata}, 32'h11);
      applyStimulus(2'b01, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
      idle(); step(2);
      checkOutput("midrst_core_ready", {31'd0, ready_M}, 32'd1);
      checkOutput("midrst_core_data", {24'd0, rd_data_M}, 32'h11);
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
